// File: rtl/riscv_pkg.sv
// Shared RV64I decode constants: opcodes, funct fields, ALU codes, ctrl bit
// positions and the decoded bundle carried through the decode buffer.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // MUL/DIV codes share the 4-bit space and are qualified by is_muldiv.
  localparam logic [3:0] MD_MUL    = 4'd0;
  localparam logic [3:0] MD_MULH   = 4'd1;
  localparam logic [3:0] MD_MULHSU = 4'd2;
  localparam logic [3:0] MD_MULHU  = 4'd3;
  localparam logic [3:0] MD_DIV    = 4'd4;
  localparam logic [3:0] MD_DIVU   = 4'd5;
  localparam logic [3:0] MD_REM    = 4'd6;
  localparam logic [3:0] MD_REMU   = 4'd7;

  localparam int CTRL_LOAD      = 0;
  localparam int CTRL_STORE     = 1;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_JAL       = 3;
  localparam int CTRL_JALR      = 4;
  localparam int CTRL_LUI       = 5;
  localparam int CTRL_AUIPC     = 6;
  localparam int CTRL_USES_IMM  = 7;
  localparam int CTRL_WORD_OP   = 8;
  localparam int CTRL_MEM_UNS   = 9;
  localparam int CTRL_MULDIV    = 10;
  localparam int CTRL_SYSTEM    = 11;
  localparam int CTRL_MEM_SIZE  = 12;

  typedef struct packed {
    logic        illegal;
    logic        fetch_err;
    logic [15:0] ctrl;
    logic [3:0]  alu_op;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } dec_bundle_t;

endpackage

// File: rtl/idecode_comb.sv
// Purely combinational RV64I decoder: instruction + fetch_err -> bundle.
// RV_M_EXT_EN enables decoding of the M extension on OP/OP-32.
module idecode_comb
  import riscv_pkg::*;
(
  input  logic [31:0]  instruction,
  input  logic         fetch_err,
  output dec_bundle_t  bundle
);

  function automatic logic [63:0] imm_i(input logic [31:0] i);
    return {{52{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] i);
    return {{52{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] i);
    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] i);
    return {{32{i[31]}}, i[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] i);
    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic        bad;
  dec_bundle_t b;

  assign opc   = instruction[6:0];
  assign f3    = instruction[14:12];
  assign f7    = instruction[31:25];
  assign rd_f  = instruction[11:7];
  assign rs1_f = instruction[19:15];
  assign rs2_f = instruction[24:20];

  always_comb begin
    b   = '0;
    bad = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        b.rd                  = rd_f;
        b.imm                 = imm_u(instruction);
        b.ctrl[CTRL_LUI]      = (opc == OPC_LUI);
        b.ctrl[CTRL_AUIPC]    = (opc == OPC_AUIPC);
        b.ctrl[CTRL_USES_IMM] = 1'b1;
      end
      OPC_JAL: begin
        b.rd                  = rd_f;
        b.imm                 = imm_j(instruction);
        b.ctrl[CTRL_JAL]      = 1'b1;
        b.ctrl[CTRL_USES_IMM] = 1'b1;
      end
      OPC_JALR: begin
        bad                   = (f3 != 3'b000);
        b.rd                  = rd_f;
        b.rs1                 = rs1_f;
        b.imm                 = imm_i(instruction);
        b.ctrl[CTRL_JALR]     = 1'b1;
        b.ctrl[CTRL_USES_IMM] = 1'b1;
      end
      OPC_BRANCH: begin
        bad                 = (f3 == 3'b010) || (f3 == 3'b011);
        b.rs1               = rs1_f;
        b.rs2               = rs2_f;
        b.imm               = imm_b(instruction);
        b.ctrl[CTRL_BRANCH] = 1'b1;
        b.alu_op            = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OPC_LOAD: begin
        bad                   = (f3 == 3'b111);
        b.rd                  = rd_f;
        b.rs1                 = rs1_f;
        b.imm                 = imm_i(instruction);
        b.ctrl[CTRL_LOAD]     = 1'b1;
        b.ctrl[CTRL_USES_IMM] = 1'b1;
        b.ctrl[CTRL_MEM_UNS]  = f3[2];
        b.ctrl[CTRL_MEM_SIZE +: 2] = f3[1:0];
      end
      OPC_STORE: begin
        bad                   = f3[2];
        b.rs1                 = rs1_f;
        b.rs2                 = rs2_f;
        b.imm                 = imm_s(instruction);
        b.ctrl[CTRL_STORE]    = 1'b1;
        b.ctrl[CTRL_USES_IMM] = 1'b1;
        b.ctrl[CTRL_MEM_SIZE +: 2] = f3[1:0];
      end
      OPC_OP_IMM: begin
        // RV64 shifts carry a 6-bit shamt, so only bits [31:26] are funct.
        b.rd                  = rd_f;
        b.rs1                 = rs1_f;
        b.imm                 = imm_i(instruction);
        b.ctrl[CTRL_USES_IMM] = 1'b1;
        b.alu_op              = alu_base(f3);
        if (f3 == F3_SLL)
          bad = (instruction[31:26] != 6'b000000);
        else if (f3 == F3_SR) begin
          bad      = (instruction[31:26] != 6'b000000) && (instruction[31:26] != 6'b010000);
          b.alu_op = instruction[30] ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_OP_IMM32: begin
        b.rd                  = rd_f;
        b.rs1                 = rs1_f;
        b.imm                 = imm_i(instruction);
        b.ctrl[CTRL_USES_IMM] = 1'b1;
        b.ctrl[CTRL_WORD_OP]  = 1'b1;
        case (f3)
          F3_ADD: b.alu_op = ALU_ADD;
          F3_SLL: begin
            bad      = (f7 != F7_BASE);
            b.alu_op = ALU_SLL;
          end
          F3_SR: begin
            bad      = (f7 != F7_BASE) && (f7 != F7_ALT);
            b.alu_op = instruction[30] ? ALU_SRA : ALU_SRL;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP, OPC_OP32: begin
        b.rd                 = rd_f;
        b.rs1                = rs1_f;
        b.rs2                = rs2_f;
        b.ctrl[CTRL_WORD_OP] = (opc == OPC_OP32);
        case (f7)
          F7_BASE: begin
            b.alu_op = alu_base(f3);
            if (opc == OPC_OP32)
              bad = (f3 != F3_ADD) && (f3 != F3_SLL) && (f3 != F3_SR);
          end
          F7_ALT: begin
            bad      = (f3 != F3_ADD) && (f3 != F3_SR);
            b.alu_op = (f3 == F3_SR) ? ALU_SRA : ALU_SUB;
          end
          F7_MULDIV: begin
`ifdef RV_M_EXT_EN
            b.ctrl[CTRL_MULDIV] = 1'b1;
            b.alu_op            = {1'b0, f3};
            if (opc == OPC_OP32)
              bad = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
`else
            bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_MISC_MEM: bad = (f3 != 3'b000);
      OPC_SYSTEM: begin
        // Only ECALL and EBREAK; imm distinguishes them.
        bad                 = (instruction != 32'h0000_0073) && (instruction != 32'h0010_0073);
        b.imm               = imm_i(instruction);
        b.ctrl[CTRL_SYSTEM] = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (bad || fetch_err) begin
      b           = '0;
      b.illegal   = ~fetch_err;
      b.fetch_err = fetch_err;
    end
  end

  assign bundle = b;

endmodule

// File: rtl/idecode.sv
// Decode stage: combinational decoder feeding an output register plus one
// skid register with valid/ready handshake. Optional M extension: RV_M_EXT_EN.
module idecode
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_current,
  input  logic            fetch_err,
  input  logic            flush,
  input  logic            dec_ready,
  output logic            fetch_stall,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic [15:0]     ctrl,
  output logic            illegal,
  output logic            dec_fetch_err
);

  dec_bundle_t     in_b, or_b, sk_b, shown;
  logic [XLEN-1:0] or_pc, sk_pc;
  logic            or_vld, sk_vld, accept, or_open;

  idecode_comb u_comb (
    .instruction (instruction),
    .fetch_err   (fetch_err),
    .bundle      (in_b)
  );

  assign accept  = instr_valid & ~flush & ~sk_vld;
  assign or_open = ~or_vld | dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
    end else if (flush) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
    end else if (or_open) begin
      or_vld <= sk_vld | accept;
      sk_vld <= 1'b0;
    end else if (accept) begin
      sk_vld <= 1'b1;
    end
  end

  // Data registers only move when their slot is free; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (or_open) begin
      or_b  <= sk_vld ? sk_b  : in_b;
      or_pc <= sk_vld ? sk_pc : pc_current;
    end
    if (!sk_vld) begin
      sk_b  <= in_b;
      sk_pc <= pc_current;
    end
  end

  assign shown         = or_vld ? or_b : '0;
  assign dec_valid     = or_vld;
  assign fetch_stall   = sk_vld;
  assign dec_pc        = or_vld ? or_pc : '0;
  assign rs1           = shown.rs1;
  assign rs2           = shown.rs2;
  assign rd            = shown.rd;
  assign imm           = shown.imm;
  assign alu_op        = shown.alu_op;
  assign ctrl          = shown.ctrl;
  assign illegal       = shown.illegal;
  assign dec_fetch_err = shown.fetch_err;

endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: decode vector table plus handshake sequences
// (backpressure, flush, mid-operation reset).
module tb_idecode;

  logic        clk, reset, instr_valid, fetch_err, flush, dec_ready;
  logic [31:0] instruction;
  logic [63:0] pc_current;
  logic        fetch_stall, dec_valid, illegal, dec_fetch_err;
  logic [63:0] dec_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic [15:0] ctrl;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] mon_q[$];

  idecode #(.XLEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .pc_current    (pc_current),
    .fetch_err     (fetch_err),
    .flush         (flush),
    .dec_ready     (dec_ready),
    .fetch_stall   (fetch_stall),
    .dec_valid     (dec_valid),
    .dec_pc        (dec_pc),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .imm           (imm),
    .alu_op        (alu_op),
    .ctrl          (ctrl),
    .illegal       (illegal),
    .dec_fetch_err (dec_fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake that completes at the coming edge.
  always @(negedge clk)
    if (!reset && !flush && dec_valid && dec_ready) mon_q.push_back(dec_pc);

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1);
  end

  typedef struct packed {
    logic [31:0] instr;
    logic        ferr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic [15:0] ctrl;
    logic        ill;
    logic        eferr;
  } vec_t;

  vec_t vt[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction and hold it until the decoder takes it.
  task automatic push(input logic [63:0] pc, input logic [31:0] ins, input string nm);
    int n;
    n = 0;
    pc_current  = pc;
    instruction = ins;
    instr_valid = 1'b1;
    while (fetch_stall && n < 20) begin
      step();
      n++;
    end
    chk({nm, " accept_in_time"}, 64'(n < 20), 64'd1);
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'hFFB10093, 1'b0, 5'd1, 5'd2, 5'd0, 64'hFFFFFFFFFFFFFFFB, 4'd0, 16'h0080, 1'b0, 1'b0};
`ifdef RV_M_EXT_EN
    vt[1]  = '{32'h022081B3, 1'b0, 5'd3, 5'd1, 5'd2, 64'h0, 4'd0, 16'h0400, 1'b0, 1'b0};
`else
    vt[1]  = '{32'h022081B3, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b1, 1'b0};
`endif
    vt[2]  = '{32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b1, 1'b0};
    vt[3]  = '{32'h00000013, 1'b1, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b0, 1'b1};
    vt[4]  = '{32'h800000B7, 1'b0, 5'd1, 5'd0, 5'd0, 64'hFFFFFFFF80000000, 4'd0, 16'h00A0, 1'b0, 1'b0};
    vt[5]  = '{32'h402081B3, 1'b0, 5'd3, 5'd1, 5'd2, 64'h0, 4'd1, 16'h0000, 1'b0, 1'b0};
    vt[6]  = '{32'hFE208EE3, 1'b0, 5'd0, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFFFC, 4'd1, 16'h0004, 1'b0, 1'b0};
    vt[7]  = '{32'h00812203, 1'b0, 5'd4, 5'd2, 5'd0, 64'h8, 4'd0, 16'h2081, 1'b0, 1'b0};
    vt[8]  = '{32'hFE513C23, 1'b0, 5'd0, 5'd2, 5'd5, 64'hFFFFFFFFFFFFFFF8, 4'd0, 16'h3082, 1'b0, 1'b0};
    vt[9]  = '{32'h001000EF, 1'b0, 5'd1, 5'd0, 5'd0, 64'h800, 4'd0, 16'h0088, 1'b0, 1'b0};
    vt[10] = '{32'h0201109B, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b1, 1'b0};
    vt[11] = '{32'h4031509B, 1'b0, 5'd1, 5'd2, 5'd0, 64'h403, 4'd7, 16'h0180, 1'b0, 1'b0};
    vt[12] = '{32'h00000073, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0800, 1'b0, 1'b0};
    vt[13] = '{32'hFFB10091, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b1, 1'b0};
    vt[14] = '{32'h0FF0000F, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b0, 1'b0};
    vt[15] = '{32'h003100BB, 1'b0, 5'd1, 5'd2, 5'd3, 64'h0, 4'd0, 16'h0100, 1'b0, 1'b0};
    vt[16] = '{32'h402090B3, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 4'd0, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1; instr_valid = 1'b1; instruction = 32'hFFB10093; pc_current = 64'h40;
    fetch_err = 1'b0; flush = 1'b0; dec_ready = 1'b1;
    repeat (2) step();
    chk("reset dec_valid", 64'(dec_valid), 64'd0);
    chk("reset fetch_stall", 64'(fetch_stall), 64'd0);
    chk("reset dec_pc", dec_pc, 64'd0);
    chk("reset imm", imm, 64'd0);
    chk("reset rd", 64'(rd), 64'd0);
    instr_valid = 1'b0;
    reset = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      instruction = vt[i].instr;
      fetch_err   = vt[i].ferr;
      pc_current  = 64'h1000 + 64'(i * 4);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      fetch_err   = 1'b0;
      chk($sformatf("v%0d dec_valid", i), 64'(dec_valid), 64'd1);
      chk($sformatf("v%0d dec_pc", i), dec_pc, 64'h1000 + 64'(i * 4));
      chk($sformatf("v%0d rd", i), 64'(rd), 64'(vt[i].rd));
      chk($sformatf("v%0d rs1", i), 64'(rs1), 64'(vt[i].rs1));
      chk($sformatf("v%0d rs2", i), 64'(rs2), 64'(vt[i].rs2));
      chk($sformatf("v%0d imm", i), imm, vt[i].imm);
      chk($sformatf("v%0d alu_op", i), 64'(alu_op), 64'(vt[i].alu));
      chk($sformatf("v%0d ctrl", i), 64'(ctrl), 64'(vt[i].ctrl));
      chk($sformatf("v%0d illegal", i), 64'(illegal), 64'(vt[i].ill));
      chk($sformatf("v%0d dec_fetch_err", i), 64'(dec_fetch_err), 64'(vt[i].eferr));
      step();
      chk($sformatf("v%0d drained", i), 64'(dec_valid), 64'd0);
    end

    // Backpressure: three back-to-back instructions with dec_ready low.
    dec_ready = 1'b0;
    mon_q.delete();
    push(64'h100, 32'hFFB10093, "bp1");
    push(64'h104, 32'h402081B3, "bp2");
    chk("bp fetch_stall", 64'(fetch_stall), 64'd1);
    chk("bp or_pc", dec_pc, 64'h100);
    pc_current = 64'h108; instruction = 32'h00812203; instr_valid = 1'b1;
    step();
    chk("bp hold dec_pc", dec_pc, 64'h100);
    chk("bp hold stall", 64'(fetch_stall), 64'd1);
    dec_ready = 1'b1;
    push(64'h108, 32'h00812203, "bp3");
    repeat (3) step();
    chk("bp count", 64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      chk("bp order0", mon_q[0], 64'h100);
      chk("bp order1", mon_q[1], 64'h104);
      chk("bp order2", mon_q[2], 64'h108);
    end

    // Flush with both registers full and an instruction on the input.
    dec_ready = 1'b0;
    push(64'h200, 32'hFFB10093, "fl1");
    push(64'h204, 32'hFFB10093, "fl2");
    chk("fl pre stall", 64'(fetch_stall), 64'd1);
    mon_q.delete();
    pc_current = 64'h208; instr_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    chk("fl dec_valid", 64'(dec_valid), 64'd0);
    chk("fl fetch_stall", 64'(fetch_stall), 64'd0);
    dec_ready = 1'b1;
    repeat (3) step();
    chk("fl nothing out", 64'(mon_q.size()), 64'd0);

    // Flush with empty buffer drops the input presented that cycle.
    pc_current = 64'h20C; instr_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    chk("fl drop dec_valid", 64'(dec_valid), 64'd0);

    // Reset while full; first instruction after release takes one cycle.
    dec_ready = 1'b0;
    push(64'h300, 32'hFFB10093, "rs1");
    push(64'h304, 32'hFFB10093, "rs2");
    pc_current = 64'h308; instr_valid = 1'b1; reset = 1'b1;
    step();
    chk("rst dec_valid", 64'(dec_valid), 64'd0);
    chk("rst fetch_stall", 64'(fetch_stall), 64'd0);
    chk("rst dec_pc", dec_pc, 64'd0);
    reset = 1'b0; dec_ready = 1'b1;
    pc_current = 64'h30C; instruction = 32'hFFB10093; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("rst post dec_valid", 64'(dec_valid), 64'd1);
    chk("rst post dec_pc", dec_pc, 64'h30C);
    chk("rst post rd", 64'(rd), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
- REQ-001 Parameter XLEN, default 64, datapath width for PC and immediate; only 64 is supported.
- REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
- REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- REQ-004 instr_valid  input  1  fetch presents an instruction this cycle.
- REQ-005 instruction  input  32  raw instruction word from fetch.
- REQ-006 pc_current  input  64  PC of the presented instruction.
- REQ-007 fetch_err  input  1  fetch reported a bus error for this instruction.
- REQ-008 flush  input  1  discard all held instructions (redirect from execute).
- REQ-009 dec_ready  input  1  execute accepts the decoded output this cycle.
- REQ-010 fetch_stall  output  1  backpressure to fetch; fetch holds its outputs while high.
- REQ-011 dec_valid  output  1  decoded bundle is valid.
- REQ-012 dec_pc  output  64  PC of the decoded instruction.
- REQ-013 rs1, rs2, rd  output  5 each  register indices; forced to 0 when the format has no such field.
- REQ-014 imm  output  64  sign-extended immediate (I/S/B/U/J), 0 for R-type.
- REQ-015 alu_op  output  4  ALU operation code from the shared package.
- REQ-016 ctrl  output  16  packed flags: is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, uses_imm, word_op, mem_unsigned, is_muldiv, is_system, mem_size[1:0], spare[1:0]=0.
- REQ-017 illegal  output  1  unsupported or malformed encoding.
- REQ-018 dec_fetch_err  output  1  fetch_err carried with the instruction.

Function
- REQ-019 The block SHALL contain an output register (OR) and one skid register (SK), each holding the valid bit plus the full decoded bundle.
- REQ-020 An input SHALL be accepted when instr_valid=1, flush=0 and SK is empty.
- REQ-021 When OR is empty or dec_ready=1, the accepted input SHALL load OR, giving dec_valid=1 the next cycle (1-cycle latency).
- REQ-022 When OR is valid and dec_ready=0, the accepted input SHALL load SK.
- REQ-023 When dec_ready=1 and SK is valid, SK SHALL move to OR and SK SHALL clear in the same cycle.
- REQ-024 fetch_stall SHALL equal the registered SK valid bit, with no combinational path from dec_ready.
- REQ-025 OR contents SHALL stay stable while dec_valid=1 and dec_ready=0.
- REQ-026 flush SHALL clear OR and SK valid bits at the next edge, SHALL take priority over simultaneous accept or transfer, and the input presented in the flush cycle SHALL be dropped.
- REQ-027 Decode SHALL cover the RV64I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32, MISC-MEM (as NOP) and SYSTEM (ECALL/EBREAK only).
- REQ-028 Any other opcode, any instruction[1:0]!=2'b11, a bad funct3/funct7, or an RV64 shift with shamt[5]=1 on a *W op SHALL set illegal=1, clear every other ctrl flag and set rd=0.
- REQ-029 An entry with fetch_err=1 SHALL set dec_fetch_err=1 and illegal=0, and SHALL otherwise be treated as illegal.
- REQ-030 The B and J immediates SHALL have bit 0 = 0, and every immediate SHALL be sign-extended from its top encoded bit to 64 bits.

Reset
- REQ-031 With reset=1 at an edge, OR and SK valid bits SHALL clear, so dec_valid=0 and fetch_stall=0 from the next cycle.
- REQ-032 During reset, the bundle outputs SHALL be 0 and inputs SHALL be ignored.
- REQ-033 Reset SHALL take priority over flush and over any in-flight transfer.

Configuration
- REQ-034 With the macro RV_M_EXT_EN defined, OP/OP-32 with funct7=0000001 SHALL decode as the M extension: is_muldiv=1 and alu_op taken from the MUL/DIV codes.
- REQ-035 Without RV_M_EXT_EN, those encodings SHALL decode as illegal.

Structure
- REQ-036 alu_op codes, the ctrl bit positions, and the opcode/funct3 constants SHALL live in the shared package riscv_pkg.
- REQ-037 Combinational decode SHALL be a sub-module idecode_comb (instruction, fetch_err -> bundle), instantiated once on the input path; idecode holds only OR, SK and the handshake.

Verification
- REQ-038 Decode test: 0xFFB10093 (ADDI x1,x2,-5) with dec_ready=1 -> one cycle later dec_valid=1, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFB, uses_imm=1, alu_op=ADD.
- REQ-039 Configuration test: 0x022081B3 (MUL x3,x1,x2) -> is_muldiv=1 with RV_M_EXT_EN defined, illegal=1 and rd=0 without it.
- REQ-040 Backpressure test: dec_ready=0 while three instructions arrive back-to-back -> OR holds #1, SK holds #2, fetch_stall=1, #3 is not accepted; raising dec_ready delivers #1, #2, #3 in order with no loss or duplicate.
- REQ-041 Flush test: flush asserted with OR and SK full and instr_valid=1 -> next cycle dec_valid=0 and fetch_stall=0, and the flushed instructions never appear at the output.
- REQ-042 Error and illegal test: fetch_err=1 with 0x00000013 -> dec_fetch_err=1 and illegal=0; 0x00000000 -> illegal=1.
- REQ-043 Mid-operation reset test: reset asserted while the buffer is full -> dec_valid=0 and fetch_stall=0 next cycle; the first instruction after release appears after exactly one cycle.
